// File: rtl/snitch_clint_pkg.sv
// Purpose: shared address map, port bundles and helpers for the Snitch CLINT.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: register offsets, mtimecmp reset value, request/response structs,
// register-port FSM states and a byte-strobe merge helper.
package snitch_clint_pkg;

  // Byte offsets of the register map (address bits [1:0] are ignored).
  localparam logic [31:0] MsipBase     = 32'h0000_0000;
  localparam logic [31:0] MtimecmpBase = 32'h0000_4000;
  localparam logic [31:0] MtimeLo      = 32'h0000_BFF8;
  localparam logic [31:0] MtimeHi      = 32'h0000_BFFC;

  // mtimecmp comes out of reset at the maximum so no timer interrupt fires.
  localparam logic [63:0] MtimecmpRst  = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } clint_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } clint_rsp_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } clint_state_e;

  // Replace the bytes of old_val selected by wstrb with the matching bytes of wdata.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/snitch_clint_timer.sv
// Purpose: RTC prescaler, 64-bit mtime counter with word-write override, per-hart mtip flops.
// Latency: mtip_o follows mtime/mtimecmp register values by one cycle.
// Backpressure: none; word writes are always accepted and win over a same-cycle tick.
// Ports: clk_i/rst_i (async active-high); mtime_we_lo_i/mtime_we_hi_i with wdata_i/wstrb_i
// select a byte-masked word write; mtimecmp_i are the per-hart compare values;
// mtime_o is the current counter; mtip_o the registered per-hart timer interrupts.
module snitch_clint_timer
  import snitch_clint_pkg::*;
#(
  parameter int unsigned NrCores = 9,
  parameter int unsigned RtcDiv  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     mtime_we_lo_i,
  input  logic                     mtime_we_hi_i,
  input  logic [31:0]              wdata_i,
  input  logic [3:0]               wstrb_i,
  input  logic [NrCores-1:0][63:0] mtimecmp_i,
  output logic [63:0]              mtime_o,
  output logic [NrCores-1:0]       mtip_o
);

  // RtcDiv == 1 still needs a one-bit prescaler that simply stays at 0.
  localparam int unsigned    PreW   = (RtcDiv > 1) ? $clog2(RtcDiv) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(RtcDiv - 1);

  logic [PreW-1:0]    presc_d, presc_q;
  logic               tick;
  logic [63:0]        mtime_d, mtime_q;
  logic [NrCores-1:0] mtip_d, mtip_q;

  always_comb begin
    tick    = (presc_q == PreMax);
    presc_d = tick ? '0 : presc_q + PreW'(1);

    // A software write replaces only the addressed word, built from the
    // pre-tick value; the tick for that cycle is dropped entirely.
    mtime_d = mtime_q;
    if (mtime_we_lo_i || mtime_we_hi_i) begin
      if (mtime_we_lo_i) mtime_d[31:0]  = apply_wstrb(mtime_q[31:0], wdata_i, wstrb_i);
      if (mtime_we_hi_i) mtime_d[63:32] = apply_wstrb(mtime_q[63:32], wdata_i, wstrb_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    for (int i = 0; i < NrCores; i++) begin
      mtip_d[i] = (mtime_q >= mtimecmp_i[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q <= '0;
      mtime_q <= '0;
      mtip_q  <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      mtip_q  <= mtip_d;
    end
  end

  assign mtime_o = mtime_q;
  assign mtip_o  = mtip_q;

endmodule

// File: rtl/snitch_clint.sv
// Purpose: core-local interruptor (msip, mtimecmp, mtime) behind a 32-bit register port.
// Latency: response valid exactly one cycle after request acceptance; one access per two cycles.
// Backpressure: response is held stable with req_ready_o low until rsp_ready_i.
// Ports: clk_i, rst_i (async active-high); req_* valid/ready request channel (byte address,
// write flag, data, strobes); rsp_* valid/ready response channel (rdata, error);
// msip_o/mtip_o per-hart software/timer interrupts.
// Build option: SNITCH_CLINT_MTIME_WRITE_EN makes mtime writable; otherwise mtime writes
// are dropped and answered with an error.
module snitch_clint
  import snitch_clint_pkg::*;
#(
  parameter int unsigned NrCores   = 9,
  parameter int unsigned RtcDiv    = 4,
  parameter int unsigned AddrWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_wstrb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic [NrCores-1:0]   msip_o,
  output logic [NrCores-1:0]   mtip_o
);

  clint_req_t                req;
  clint_rsp_t                rsp_d, rsp_q;
  clint_state_e              state_d, state_q;
  logic [NrCores-1:0]        msip_d, msip_q;
  logic [NrCores-1:0][63:0]  mtimecmp_d, mtimecmp_q;
  logic [63:0]               mtime;
  logic                      req_hs;
  logic                      mtime_we_lo, mtime_we_hi;
  logic [31:0]               off, msip_idx, cmp_idx;
  logic                      hit_msip, hit_cmp, hit_mtime_lo, hit_mtime_hi;

  assign req = '{addr: 32'(req_addr_i), write: req_write_i,
                 wdata: req_wdata_i, wstrb: req_wstrb_i};

  // Decode: msip occupies [0x0000, 0x4000), mtimecmp [0x4000, 0xBFF8); slots
  // past the last hart are treated as unmapped.
  always_comb begin
    off          = req.addr & 32'hFFFF_FFFC;
    msip_idx     = (off - MsipBase) >> 2;
    cmp_idx      = (off - MtimecmpBase) >> 3;
    hit_msip     = (off < MtimecmpBase) && (msip_idx < NrCores);
    hit_cmp      = (off >= MtimecmpBase) && (off < MtimeLo) && (cmp_idx < NrCores);
    hit_mtime_lo = (off == MtimeLo);
    hit_mtime_hi = (off == MtimeHi);
  end

  // Ready is forced low while reset is asserted so all outputs read 0 then.
  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign req_hs      = req_valid_i && req_ready_o;

  always_comb begin
    state_d     = state_q;
    rsp_d       = rsp_q;
    msip_d      = msip_q;
    mtimecmp_d  = mtimecmp_q;
    mtime_we_lo = 1'b0;
    mtime_we_hi = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_hs) begin
          state_d = RESP;
          rsp_d   = '0;
          if (hit_msip) begin
            for (int i = 0; i < NrCores; i++) begin
              if (msip_idx == i) begin
                if (req.write) begin
                  if (req.wstrb[0]) msip_d[i] = req.wdata[0];
                end else begin
                  rsp_d.rdata = {31'b0, msip_q[i]};
                end
              end
            end
          end else if (hit_cmp) begin
            for (int i = 0; i < NrCores; i++) begin
              if (cmp_idx == i) begin
                if (req.write) begin
                  if (off[2]) mtimecmp_d[i][63:32] =
                      apply_wstrb(mtimecmp_q[i][63:32], req.wdata, req.wstrb);
                  else        mtimecmp_d[i][31:0]  =
                      apply_wstrb(mtimecmp_q[i][31:0], req.wdata, req.wstrb);
                end else begin
                  rsp_d.rdata = off[2] ? mtimecmp_q[i][63:32] : mtimecmp_q[i][31:0];
                end
              end
            end
          end else if (hit_mtime_lo || hit_mtime_hi) begin
            if (req.write) begin
`ifdef SNITCH_CLINT_MTIME_WRITE_EN
              // An all-zero strobe is a no-op and must not swallow the tick.
              mtime_we_lo = hit_mtime_lo && (|req.wstrb);
              mtime_we_hi = hit_mtime_hi && (|req.wstrb);
`else
              rsp_d.error = 1'b1;
`endif
            end else begin
              rsp_d.rdata = hit_mtime_hi ? mtime[63:32] : mtime[31:0];
            end
          end else begin
            rsp_d.error = 1'b1;
          end
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rsp_q      <= '0;
      msip_q     <= '0;
      mtimecmp_q <= {NrCores{MtimecmpRst}};
    end else begin
      state_q    <= state_d;
      rsp_q      <= rsp_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  snitch_clint_timer #(
    .NrCores (NrCores),
    .RtcDiv  (RtcDiv)
  ) i_timer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mtime_we_lo_i (mtime_we_lo),
    .mtime_we_hi_i (mtime_we_hi),
    .wdata_i       (req.wdata),
    .wstrb_i       (req.wstrb),
    .mtimecmp_i    (mtimecmp_q),
    .mtime_o       (mtime),
    .mtip_o        (mtip_o)
  );

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_error_o = rsp_q.error;
  assign msip_o      = msip_q;

endmodule

// File: tb/tb_snitch_clint.sv
// Purpose: directed self-checking bench for snitch_clint (NrCores=9, RtcDiv=4, AddrWidth=16).
// Latency: checks the one-cycle response latency and interrupt timing.
// Backpressure: exercises a stalled response with a second pending request.
module tb_snitch_clint;

  logic        clk_i, rst_i;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [15:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_error_o;
  logic [31:0] rsp_rdata_o;
  logic [8:0]  msip_o, mtip_o;

  int checks = 0;
  int errors = 0;
  int tmo    = 0;
  int cyc    = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  snitch_clint #(.NrCores(9), .RtcDiv(4), .AddrWidth(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_write_i(req_write_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o), .msip_o(msip_o), .mtip_o(mtip_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Posedges since the last reset release: mtime ticks on every 4th one.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // One request/response exchange with rsp_ready_i high; lat is the number of
  // cycles from acceptance until rsp_valid_o is seen (99 on timeout).
  task automatic access(input logic [15:0] a, input logic w, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] r, output logic e,
                        output int l);
    int n;
    r = '0; e = 1'b0; l = 99;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = a; req_write_i = w; req_wdata_i = wd; req_wstrb_i = ws;
    n = 0;
    while (req_ready_o !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 20) begin
      tmo++;
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    l = 1;
    while (rsp_valid_o !== 1'b1 && l < 20) begin
      @(negedge clk_i);
      l++;
    end
    if (l >= 20) begin
      tmo++;
      l = 99;
      return;
    end
    r = rsp_rdata_o;
    e = rsp_error_o;
    @(posedge clk_i);
    #1;
  endtask

  // Return at the negedge where cyc equals t (always advances at least one negedge).
  task automatic wait_cyc(input int t);
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (cyc != t && n < 500);
    if (cyc != t) tmo++;
  endtask

  task automatic reset_dut();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (msip_o !== 9'h0 || mtip_o !== 9'h0) begin errors++;
      $display("FAIL reset_irq: msip=%h mtip=%h expected 0/0", msip_o, mtip_o); end
    checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || rsp_rdata_o !== 32'h0) begin errors++;
      $display("FAIL reset_port: rsp_valid=%b req_ready=%b rdata=%h expected 0/0/0",
               rsp_valid_o, req_ready_o, rsp_rdata_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++; if (req_ready_o !== 1'b1) begin errors++;
      $display("FAIL ready_after_reset: got %b expected 1", req_ready_o); end
    // Leave a response outstanding, then reset mid-cycle.
    access(16'h0000, 1'b1, 32'h1, 4'hF, rd, er, lat);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_addr_i = 16'h0000; req_write_i = 1'b0;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    #2;
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h1 || msip_o !== 9'h001) begin errors++;
      $display("FAIL pre_reset_state: valid=%b rdata=%h msip=%h expected 1/1/001",
               rsp_valid_o, rsp_rdata_o, msip_o); end
    rst_i = 1'b1;
    #1;
    checks++; if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_error_o !== 1'b0) begin errors++;
      $display("FAIL async_reset_rsp: valid=%b rdata=%h err=%b expected 0/0/0",
               rsp_valid_o, rsp_rdata_o, rsp_error_o); end
    checks++; if (msip_o !== 9'h0 || mtip_o !== 9'h0 || req_ready_o !== 1'b0) begin errors++;
      $display("FAIL async_reset_out: msip=%h mtip=%h ready=%b expected 0/0/0",
               msip_o, mtip_o, req_ready_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    rsp_ready_i = 1'b1;
    #1;
    checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++;
      $display("FAIL reset_drop_rsp: valid=%b ready=%b expected 0/1", rsp_valid_o, req_ready_o); end
    access(16'h4000, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_FFFF || er !== 1'b0) begin errors++;
      $display("FAIL reset_mtimecmp_lo: rdata=%h err=%b expected ffffffff/0", rd, er); end
    access(16'h4004, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_FFFF || er !== 1'b0) begin errors++;
      $display("FAIL reset_mtimecmp_hi: rdata=%h err=%b expected ffffffff/0", rd, er); end
    access(16'h0000, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin errors++;
      $display("FAIL reset_msip0: rdata=%h expected 0", rd); end
  endtask

  task automatic test_msip();
    access(16'h0008, 1'b1, 32'h1, 4'hF, rd, er, lat);
    checks++; if (lat !== 1 || er !== 1'b0) begin errors++;
      $display("FAIL msip_wr_rsp: latency=%0d err=%b expected 1/0", lat, er); end
    checks++; if (msip_o !== 9'b000000100) begin errors++;
      $display("FAIL msip_set: msip=%b expected 000000100", msip_o); end
    access(16'h000B, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h1 || er !== 1'b0 || lat !== 1) begin errors++;
      $display("FAIL msip_rd: rdata=%h err=%b lat=%0d expected 1/0/1", rd, er, lat); end
    // Bit 0 strobe off: nothing changes.
    access(16'h0008, 1'b1, 32'h0, 4'b1110, rd, er, lat);
    checks++; if (msip_o !== 9'b000000100 || er !== 1'b0) begin errors++;
      $display("FAIL msip_strb: msip=%b err=%b expected 000000100/0", msip_o, er); end
    access(16'h0008, 1'b1, 32'hFFFF_FFFE, 4'hF, rd, er, lat);
    checks++; if (msip_o !== 9'h0) begin errors++;
      $display("FAIL msip_clr: msip=%b expected 000000000", msip_o); end
    access(16'h4010, 1'b1, 32'h1234_5678, 4'b0101, rd, er, lat);
    access(16'h4010, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'hFF34_FF78 || er !== 1'b0) begin errors++;
      $display("FAIL mtimecmp_bytes: rdata=%h err=%b expected ff34ff78/0", rd, er); end
    access(16'h4014, 1'b1, 32'h0, 4'h0, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++;
      $display("FAIL wstrb0_noerr: err=%b expected 0", er); end
  endtask

  task automatic test_errors();
    access(16'h0024, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++;
      $display("FAIL err_msip9_rd: err=%b rdata=%h expected 1/0", er, rd); end
    access(16'h0024, 1'b1, 32'h1, 4'hF, rd, er, lat);
    checks++; if (er !== 1'b1 || msip_o !== 9'h0) begin errors++;
      $display("FAIL err_msip9_wr: err=%b msip=%b expected 1/0", er, msip_o); end
    access(16'h4048, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++;
      $display("FAIL err_cmp9: err=%b rdata=%h expected 1/0", er, rd); end
    access(16'hC000, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++;
      $display("FAIL err_unmapped: err=%b rdata=%h expected 1/0", er, rd); end
    access(16'hBFFC, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++;
      $display("FAIL mtime_rd_legal: err=%b expected 0", er); end
  endtask

  task automatic test_backpressure();
    access(16'h0008, 1'b1, 32'h1, 4'hF, rd, er, lat);
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1; req_addr_i = 16'h0008; req_write_i = 1'b0;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h1 || req_ready_o !== 1'b0) begin errors++;
        $display("FAIL bp_hold%0d: valid=%b rdata=%h ready=%b expected 1/1/0",
                 k, rsp_valid_o, rsp_rdata_o, req_ready_o); end
    end
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 16'h4000; req_write_i = 1'b0;
    #1;
    checks++; if (req_ready_o !== 1'b0) begin errors++;
      $display("FAIL bp_pending: ready=%b expected 0", req_ready_o); end
    @(negedge clk_i);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++;
      $display("FAIL bp_release: valid=%b ready=%b expected 0/1", rsp_valid_o, req_ready_o); end
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hFFFF_FFFF || rsp_error_o !== 1'b0) begin errors++;
      $display("FAIL bp_second: valid=%b rdata=%h err=%b expected 1/ffffffff/0",
               rsp_valid_o, rsp_rdata_o, rsp_error_o); end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_timer();
    reset_dut();
    access(16'h4008, 1'b1, 32'h5, 4'hF, rd, er, lat);
    access(16'h400C, 1'b1, 32'h0, 4'hF, rd, er, lat);
    checks++; if (mtip_o !== 9'h0) begin errors++;
      $display("FAIL mtip_early: mtip=%b expected 0", mtip_o); end
    wait_cyc(20);
    checks++; if (mtip_o !== 9'h0) begin errors++;
      $display("FAIL mtip_before: mtip=%b expected 000000000", mtip_o); end
    wait_cyc(21);
    checks++; if (mtip_o !== 9'b000000010) begin errors++;
      $display("FAIL mtip_rise: mtip=%b expected 000000010", mtip_o); end
  endtask

  task automatic test_mtime_write();
    reset_dut();
    access(16'hBFF8, 1'b1, 32'h1000, 4'hF, rd, er, lat);
`ifdef SNITCH_CLINT_MTIME_WRITE_EN
    checks++; if (er !== 1'b0) begin errors++;
      $display("FAIL mtime_wr_err: err=%b expected 0", er); end
    wait_cyc(10);
    access(16'hBFF8, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h1002) begin errors++;
      $display("FAIL mtime_wr_count: rdata=%h expected 00001002", rd); end
`else
    checks++; if (er !== 1'b1) begin errors++;
      $display("FAIL mtime_wr_err: err=%b expected 1", er); end
    wait_cyc(10);
    access(16'hBFF8, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h2) begin errors++;
      $display("FAIL mtime_ro_count: rdata=%h expected 00000002", rd); end
`endif
  endtask

`ifdef SNITCH_CLINT_MTIME_WRITE_EN
  task automatic test_wrap_collision();
    reset_dut();
    wait_cyc(10);
    access(16'hBFFC, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    wait_cyc(16);
    access(16'hBFF8, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    wait_cyc(19);
    checks++; if (mtip_o !== 9'h1FF) begin errors++;
      $display("FAIL mtip_max: mtip=%b expected 111111111", mtip_o); end
    access(16'hBFF8, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin errors++;
      $display("FAIL wrap_lo: rdata=%h expected 0", rd); end
    access(16'hBFFC, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin errors++;
      $display("FAIL wrap_hi: rdata=%h expected 0", rd); end
    // Hi write on a tick edge while lo is all-ones: no carry, lo unchanged.
    wait_cyc(27);
    access(16'hBFF8, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    wait_cyc(30);
    access(16'hBFFC, 1'b1, 32'h5, 4'hF, rd, er, lat);
    access(16'hBFF8, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++;
      $display("FAIL coll_hi_keep_lo: rdata=%h expected ffffffff", rd); end
    access(16'hBFFC, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h5) begin errors++;
      $display("FAIL coll_hi_val: rdata=%h expected 00000005", rd); end
    // Lo write on a tick edge: written value is not incremented.
    wait_cyc(38);
    access(16'hBFF8, 1'b1, 32'h100, 4'hF, rd, er, lat);
    access(16'hBFF8, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h100) begin errors++;
      $display("FAIL coll_lo_val: rdata=%h expected 00000100", rd); end
    access(16'hBFFC, 1'b0, 32'h0, 4'h0, rd, er, lat);
    checks++; if (rd !== 32'h6) begin errors++;
      $display("FAIL coll_lo_keep_hi: rdata=%h expected 00000006", rd); end
  endtask
`endif

  task automatic test_timeouts();
    checks++; if (tmo !== 0) begin errors++;
      $display("FAIL handshake_timeouts: got %0d expected 0", tmo); end
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_write_i = 1'b0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    rsp_ready_i = 1'b1;
    test_reset();
    test_msip();
    test_errors();
    test_backpressure();
    test_timer();
    test_mtime_write();
`ifdef SNITCH_CLINT_MTIME_WRITE_EN
    test_wrap_collision();
`endif
    test_timeouts();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snitch_clint.md
Name: snitch_clint

Overview:
- Synthesizable core-local interruptor for the Snitch cluster testbench and top-level integration. It replaces the DPI-driven msip source.
- Exposes a 32-bit memory-mapped register port carrying per-core msip, per-core mtimecmp and a global mtime.
- Drives msip_o and mtip_o straight into the cluster's msip_i and mtip_i inputs.
- Sits between the narrow interconnect (AXI-to-reg adapter, outside this block) and the cluster wrapper.

Parameters:
- NrCores, 9, number of harts; width of msip_o and mtip_o.
- RtcDiv, 4, clk_i cycles per mtime increment; must be >= 1; 1 means increment every cycle.
- AddrWidth, 16, byte-address width of the register port.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when req_valid_i && req_ready_o.
- req_addr_i  in  AddrWidth  byte address; bits [1:0] ignored.
- req_write_i  in  1  1 = write, 0 = read.
- req_wdata_i  in  32  write data.
- req_wstrb_i  in  4  byte enables for writes.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when rsp_valid_o && rsp_ready_i.
- rsp_rdata_o  out  32  read data; 0 for writes and errors.
- rsp_error_o  out  1  unmapped or illegal access.
- msip_o  out  NrCores  software interrupt per hart.
- mtip_o  out  NrCores  timer interrupt per hart.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is asynchronous, active-high.
- Reset values:
  - msip regs 0; mtimecmp regs all-ones (64'hFFFF_FFFF_FFFF_FFFF); mtime 0; prescaler 0.
  - rsp_valid_o 0, rsp_rdata_o 0, rsp_error_o 0, msip_o 0, mtip_o 0.
  - req_ready_o 1 from the first cycle after reset.
- Address map (offsets within AddrWidth):
  - msip[i] at 0x0000+4*i; bit 0 only; upper bits read 0.
  - mtimecmp[i] low word at 0x4000+8*i, high word at +4.
  - mtime low word at 0xBFF8, high word at 0xBFFC.
- Register port state machine, states IDLE and RESP:
  - IDLE: req_ready_o=1. On handshake, perform the access and register the response; next state RESP.
  - RESP: rsp_valid_o=1 and req_ready_o=0. Leave to IDLE on rsp_ready_i.
  - Latency: response valid exactly 1 cycle after request acceptance. Throughput: one access per 2 cycles at most.
- Writes: byte-granular per req_wstrb_i; wstrb=0 is a legal no-op with no error.
- Reads: return the register value as of the acceptance cycle, before any same-cycle tick.
- Unmapped address, or hart index >= NrCores: rsp_error_o=1, rdata 0, no state change.
- mtime:
  - Prescaler counts 0..RtcDiv-1; on wrap, mtime increments by 1.
  - mtime wraps from 2^64-1 to 0.
  - A software write to an mtime word in the same cycle as a tick wins; the tick is lost for that cycle.
  - The written word takes the new value; the other word keeps its pre-tick value.
- mtip_o[i] is registered: mtip_o[i] <= (mtime >= mtimecmp[i]), unsigned 64-bit compare using current register values. It therefore lags register updates by 1 cycle.
- msip_o[i] is a direct output of the msip[i] flop; it goes high the cycle after the write handshake.
- Reset mid-transaction: an outstanding response is dropped, the FSM returns to IDLE and all registers take their reset values.

Optional Feature:
- Macro: SNITCH_CLINT_MTIME_WRITE_EN.
- Defined: mtime words are software-writable as described above.
- Undefined: writes to 0xBFF8/0xBFFC are ignored and answered with rsp_error_o=1. mtime reads remain legal.

Decomposition:
- Package snitch_clint_pkg holds:
  - address offset constants MsipBase, MtimecmpBase, MtimeLo, MtimeHi;
  - typedef clint_req_t and clint_rsp_t bundling the port fields;
  - the mtimecmp reset constant.
- One sub-module, snitch_clint_timer, holds the prescaler, the mtime counter with word-write override, and the per-hart mtip compare flops.
- The top module holds the FSM, the decoder and the msip/mtimecmp storage.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle -> all outputs 0 immediately; read mtimecmp[0] lo after release -> 0xFFFFFFFF, error 0.
- msip: write 0x1 to 0x0008 (hart 2) -> msip_o=9'b000000100 on the cycle after the handshake; response 1 cycle after acceptance; read back -> 0x1; write 0xFFFFFFFE -> msip_o[2]=0.
- Timer: RtcDiv=4; write mtimecmp[1] = 0x0000_0000_0000_0005 (lo then hi) -> mtip_o[1] rises 1 cycle after mtime reaches 5, i.e. within cycle 21 after reset; other mtip bits stay 0.
- Wrap and collision (macro defined): write mtime lo 0xFFFFFFFF, hi 0xFFFFFFFF -> after one tick, reads return 0/0. A write landing on a tick cycle leaves the written value unincremented.
- Errors: read 0x0024 (hart 9 with NrCores=9) -> rsp_error_o=1, rdata 0. Without the macro, write 0xBFF8 -> error 1 and mtime keeps counting.
- Backpressure: hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o and data stable, req_ready_o=0. A second request stays pending until one cycle after rsp_ready_i rises.
